// File: rtl/div_sequencer_pkg.sv
// div_sequencer_pkg
// Shared types and constants for the divide sequencer slice.
//   div_state_t            : sequencer FSM state encoding
//   DEFAULT_TIMEOUT_CYCLES : watchdog limit for cycles spent in ISSUE/DRAIN
//   DEFAULT_DATA_WIDTH     : operand/result width
package div_sequencer_pkg;

  localparam int DEFAULT_TIMEOUT_CYCLES = 34;
  localparam int DEFAULT_DATA_WIDTH     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } div_state_t;

  // True while a request is outstanding at the divider.
  function automatic logic is_waiting(input div_state_t s);
    return (s == ISSUE) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// div_sequencer_if
// Request/response bus between the divide sequencer and the iterative divider.
//   divide_request_valid : request held until divide_result_valid is seen
//   is_signed_input      : 1 = signed divide
//   input1 / input2      : dividend / divisor
//   divide_result        : quotient
//   divide_remain        : remainder
//   divide_result_valid  : quotient/remainder are valid this cycle
// Modports: master = sequencer side, slave = divider side.
interface div_sequencer_if
  import div_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  divide_request_valid;
  logic                  is_signed_input;
  logic [DATA_WIDTH-1:0] input1;
  logic [DATA_WIDTH-1:0] input2;
  logic [DATA_WIDTH-1:0] divide_result;
  logic [DATA_WIDTH-1:0] divide_remain;
  logic                  divide_result_valid;

  modport master (
    output divide_request_valid,
    output is_signed_input,
    output input1,
    output input2,
    input  divide_result,
    input  divide_remain,
    input  divide_result_valid
  );

  modport slave (
    input  divide_request_valid,
    input  is_signed_input,
    input  input1,
    input  input2,
    output divide_result,
    output divide_remain,
    output divide_result_valid
  );

endinterface

// File: rtl/div_sequencer_watchdog.sv
// div_watchdog
// Counts cycles while the sequencer waits on the divider and flags an abort
// once the wait reaches TIMEOUT_CYCLES.
//   clock         : rising-edge clock
//   reset         : asynchronous active-low reset
//   active        : sequencer is in ISSUE or DRAIN
//   expired       : this is the final permitted waiting cycle (combinational)
//   timeout_error : sticky flag, set when expired, cleared only by reset
module div_watchdog
  import div_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  output logic expired,
  output logic timeout_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // count holds the number of waiting cycles already completed, so the
  // TIMEOUT_CYCLES-th waiting cycle is the one where count == TIMEOUT_CYCLES-1.
  assign expired = active && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count         <= '0;
      timeout_error <= 1'b0;
    end else begin
      if (!active) begin
        count <= '0;
      end else if (!expired) begin
        count <= count + CW'(1);
      end
      if (expired) begin
        timeout_error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// div_sequencer
// Sequences a DIV/DIVU instruction from the EX stage through a multi-cycle
// divider and writes quotient to LO and remainder to HI.
// Optional feature macro: DIV_ZERO_BYPASS_EN -- a zero divisor skips the
// divider and completes in two cycles with LO = all ones, HI = dividend.
// Ports:
//   clock, reset                 : rising-edge clock, async active-low reset
//   ex_div_valid, ex_div_signed  : EX holds a divide; 1 = DIV, 0 = DIVU
//   ex_src1, ex_src2             : dividend, divisor
//   ex_flush                     : cancel the in-flight EX instruction
//   ex_stall                     : hold the EX stage
//   div_bus                      : divider request/response (master side)
//   hi/lo_write_enable, _data    : HI/LO register file write
//   busy                         : sequencer not idle
//   timeout_error                : sticky watchdog abort flag
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ex_div_valid,
  input  logic                  ex_div_signed,
  input  logic [DATA_WIDTH-1:0] ex_src1,
  input  logic [DATA_WIDTH-1:0] ex_src2,
  input  logic                  ex_flush,
  output logic                  ex_stall,
  div_sequencer_if.master       div_bus,
  output logic                  hi_write_enable,
  output logic                  lo_write_enable,
  output logic [DATA_WIDTH-1:0] hi_write_data,
  output logic [DATA_WIDTH-1:0] lo_write_data,
  output logic                  busy,
  output logic                  timeout_error
);

  div_state_t            state;
  logic                  signed_q;
  logic [DATA_WIDTH-1:0] src1_q;
  logic [DATA_WIDTH-1:0] src2_q;
  logic [DATA_WIDTH-1:0] hi_buf;
  logic [DATA_WIDTH-1:0] lo_buf;
  logic                  request_q;
  logic                  wd_expired;

  div_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock         (clock),
    .reset         (reset),
    .active        (is_waiting(state)),
    .expired       (wd_expired),
    .timeout_error (timeout_error)
  );

  // Main sequencer. The watchdog abort outranks everything else while
  // waiting; a result arriving together with a flush in ISSUE is dropped
  // because the instruction it belongs to has been cancelled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      signed_q  <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      hi_buf    <= '0;
      lo_buf    <= '0;
      request_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_div_valid && !ex_flush) begin
            signed_q <= ex_div_signed;
            src1_q   <= ex_src1;
            src2_q   <= ex_src2;
`ifdef DIV_ZERO_BYPASS_EN
            if (ex_src2 == '0) begin
              lo_buf <= '1;
              hi_buf <= ex_src1;
              state  <= DONE;
            end else begin
              request_q <= 1'b1;
              state     <= ISSUE;
            end
`else
            request_q <= 1'b1;
            state     <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          if (wd_expired) begin
            request_q <= 1'b0;
            state     <= IDLE;
          end else if (div_bus.divide_result_valid) begin
            request_q <= 1'b0;
            if (ex_flush) begin
              state <= IDLE;
            end else begin
              lo_buf <= div_bus.divide_result;
              hi_buf <= div_bus.divide_remain;
              state  <= DONE;
            end
          end else if (ex_flush) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (wd_expired || div_bus.divide_result_valid) begin
            request_q <= 1'b0;
            state     <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          request_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // The divider only ever sees latched operands, so EX may change freely.
  assign div_bus.divide_request_valid = request_q;
  assign div_bus.is_signed_input      = signed_q;
  assign div_bus.input1               = src1_q;
  assign div_bus.input2               = src2_q;

  // The write happens in the DONE cycle itself, so a flush arriving in that
  // same cycle must still be able to suppress it.
  assign hi_write_enable = (state == DONE) && !ex_flush;
  assign lo_write_enable = (state == DONE) && !ex_flush;
  assign hi_write_data   = hi_buf;
  assign lo_write_data   = lo_buf;

  assign busy = (state != IDLE);

  // Gated by reset so every output reads zero while reset is held.
  assign ex_stall = reset && ex_div_valid && (state != DONE);

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
// Directed self-checking bench for div_sequencer. The bench plays the role
// of the divider, returning hand-computed quotient/remainder pairs.
module tb_div_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ex_div_valid = 1'b0;
  logic        ex_div_signed = 1'b0;
  logic [31:0] ex_src1 = '0;
  logic [31:0] ex_src2 = '0;
  logic        ex_flush = 1'b0;
  logic        ex_stall;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wd;
  logic [31:0] lo_wd;
  logic        busy;
  logic        timeout_error;

  int tests_run = 0;
  int tests_failed = 0;

  div_sequencer_if #(.DATA_WIDTH(32)) div_bus ();

  div_sequencer #(
    .TIMEOUT_CYCLES(34),
    .DATA_WIDTH    (32)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .ex_div_valid    (ex_div_valid),
    .ex_div_signed   (ex_div_signed),
    .ex_src1         (ex_src1),
    .ex_src2         (ex_src2),
    .ex_flush        (ex_flush),
    .ex_stall        (ex_stall),
    .div_bus         (div_bus),
    .hi_write_enable (hi_we),
    .lo_write_enable (lo_we),
    .hi_write_data   (hi_wd),
    .lo_write_data   (lo_wd),
    .busy            (busy),
    .timeout_error   (timeout_error)
  );

  always #5 clock = ~clock;

  // Hard stop in case something wedges the bench itself.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] bench did not complete");
  end

  // Present a divide to EX on a falling edge; it is accepted on the next rise.
  task automatic drive_op(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ex_div_valid  = 1'b1;
    ex_div_signed = s;
    ex_src1       = a;
    ex_src2       = b;
  endtask

  task automatic test_reset();
    div_bus.divide_result_valid = 1'b0;
    div_bus.divide_result       = '0;
    div_bus.divide_remain       = '0;
    reset = 1'b0;
    @(negedge clock); #1;
    tests_run++; if (div_bus.divide_request_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_req: got %b expected 0", div_bus.divide_request_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall: got %b expected 0", ex_stall); end
    tests_run++; if ({hi_we, lo_we} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_we: got %b expected 00", {hi_we, lo_we}); end
    tests_run++; if (lo_wd !== 32'h0 || hi_wd !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_wdata: got %h/%h expected 0/0", hi_wd, lo_wd); end
    tests_run++; if (timeout_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout: got %b expected 0", timeout_error); end
    tests_run++; if (div_bus.input1 !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_input1: got %h expected 0", div_bus.input1); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_divu();
    drive_op(1'b0, 32'd100, 32'd7);
    #1;
    tests_run++; if (ex_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL divu_accept_stall: got %b expected 1", ex_stall); end
    @(negedge clock); #1;
    tests_run++; if (div_bus.divide_request_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL divu_req: got %b expected 1", div_bus.divide_request_valid); end
    tests_run++; if (div_bus.input1 !== 32'd100 || div_bus.input2 !== 32'd7) begin tests_failed++; $display("[TB] FAIL divu_operands: got %0d/%0d expected 100/7", div_bus.input1, div_bus.input2); end
    tests_run++; if (div_bus.is_signed_input !== 1'b0) begin tests_failed++; $display("[TB] FAIL divu_signed: got %b expected 0", div_bus.is_signed_input); end
    repeat (3) @(negedge clock);
    #1;
    tests_run++; if (div_bus.divide_request_valid !== 1'b1 || ex_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL divu_req_held: got %b/%b expected 1/1", div_bus.divide_request_valid, ex_stall); end
    @(negedge clock);
    div_bus.divide_result_valid = 1'b1;
    div_bus.divide_result       = 32'd14;
    div_bus.divide_remain       = 32'd2;
    @(negedge clock);
    div_bus.divide_result_valid = 1'b0;
    #1;
    tests_run++; if ({hi_we, lo_we} !== 2'b11) begin tests_failed++; $display("[TB] FAIL divu_we: got %b expected 11", {hi_we, lo_we}); end
    tests_run++; if (lo_wd !== 32'd14 || hi_wd !== 32'd2) begin tests_failed++; $display("[TB] FAIL divu_data: got lo=%0d hi=%0d expected lo=14 hi=2", lo_wd, hi_wd); end
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL divu_stall_drop: got %b expected 0", ex_stall); end
    tests_run++; if (div_bus.divide_request_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL divu_req_drop: got %b expected 0", div_bus.divide_request_valid); end
    ex_div_valid = 1'b0;
    @(negedge clock); #1;
    tests_run++; if (busy !== 1'b0 || lo_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL divu_idle: got busy=%b we=%b expected 0/0", busy, lo_we); end
  endtask

  task automatic test_divs();
    int signed_bad;
    signed_bad = 0;
    drive_op(1'b1, 32'hFFFF_FF9C, 32'd7);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clock); #1;
      if (div_bus.is_signed_input !== 1'b1 || div_bus.divide_request_valid !== 1'b1) signed_bad++;
      if (i == 3) begin
        div_bus.divide_result_valid = 1'b1;
        div_bus.divide_result       = 32'hFFFF_FFF2;
        div_bus.divide_remain       = 32'hFFFF_FFFE;
      end
    end
    tests_run++; if (signed_bad !== 0) begin tests_failed++; $display("[TB] FAIL divs_signed_held: got %0d bad cycles expected 0", signed_bad); end
    @(negedge clock);
    div_bus.divide_result_valid = 1'b0;
    #1;
    tests_run++; if (lo_we !== 1'b1 || lo_wd !== 32'hFFFF_FFF2) begin tests_failed++; $display("[TB] FAIL divs_lo: got we=%b %h expected 1 fffffff2", lo_we, lo_wd); end
    tests_run++; if (hi_we !== 1'b1 || hi_wd !== 32'hFFFF_FFFE) begin tests_failed++; $display("[TB] FAIL divs_hi: got we=%b %h expected 1 fffffffe", hi_we, hi_wd); end
    ex_div_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_flush_idle();
    @(negedge clock);
    ex_div_valid = 1'b1;
    ex_flush     = 1'b1;
    ex_src2      = 32'd3;
    @(negedge clock); #1;
    tests_run++; if (busy !== 1'b0 || div_bus.divide_request_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_idle_accept: got busy=%b req=%b expected 0/0", busy, div_bus.divide_request_valid); end
    ex_div_valid = 1'b0;
    ex_flush     = 1'b0;
  endtask

  task automatic test_flush();
    int we_seen;
    we_seen = 0;
    drive_op(1'b0, 32'd50, 32'd5);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    ex_flush     = 1'b1;
    ex_div_valid = 1'b0;
    @(negedge clock);
    ex_flush      = 1'b0;
    ex_div_valid  = 1'b1;
    ex_div_signed = 1'b1;
    ex_src1       = 32'd81;
    ex_src2       = 32'd9;
    #1;
    tests_run++; if (div_bus.divide_request_valid !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_req_held: got req=%b busy=%b expected 1/1", div_bus.divide_request_valid, busy); end
    tests_run++; if (ex_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL drain_stall: got %b expected 1", ex_stall); end
    tests_run++; if (div_bus.input1 !== 32'd50 || div_bus.is_signed_input !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_operands: got %0d/%b expected 50/0", div_bus.input1, div_bus.is_signed_input); end
    if (hi_we || lo_we) we_seen++;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      if (hi_we || lo_we) we_seen++;
    end
    div_bus.divide_result_valid = 1'b1;
    div_bus.divide_result       = 32'd10;
    div_bus.divide_remain       = 32'd0;
    @(negedge clock);
    div_bus.divide_result_valid = 1'b0;
    #1;
    if (hi_we || lo_we) we_seen++;
    tests_run++; if (we_seen !== 0) begin tests_failed++; $display("[TB] FAIL drain_no_write: got %0d write cycles expected 0", we_seen); end
    tests_run++; if (busy !== 1'b0 || div_bus.divide_request_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_to_idle: got busy=%b req=%b expected 0/0", busy, div_bus.divide_request_valid); end
    tests_run++; if (ex_stall !== 1'b1) begin tests_failed++; $display("[TB] FAIL pending_stall: got %b expected 1", ex_stall); end
    @(negedge clock); #1;
    tests_run++; if (busy !== 1'b1 || div_bus.input1 !== 32'd81 || div_bus.is_signed_input !== 1'b1) begin tests_failed++; $display("[TB] FAIL pending_accept: got busy=%b in1=%0d s=%b expected 1/81/1", busy, div_bus.input1, div_bus.is_signed_input); end
    div_bus.divide_result_valid = 1'b1;
    div_bus.divide_result       = 32'd9;
    div_bus.divide_remain       = 32'd0;
    @(negedge clock);
    div_bus.divide_result_valid = 1'b0;
    ex_flush = 1'b1;
    #1;
    tests_run++; if ({hi_we, lo_we} !== 2'b00) begin tests_failed++; $display("[TB] FAIL done_flush_we: got %b expected 00", {hi_we, lo_we}); end
    ex_flush     = 1'b0;
    ex_div_valid = 1'b0;
    @(negedge clock); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_flush_idle: got %b expected 0", busy); end
  endtask

  task automatic test_div_zero();
    drive_op(1'b0, 32'd77, 32'd0);
    @(negedge clock); #1;
`ifdef DIV_ZERO_BYPASS_EN
    tests_run++; if (div_bus.divide_request_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_bypass_req: got %b expected 0", div_bus.divide_request_valid); end
    tests_run++; if (lo_we !== 1'b1 || lo_wd !== 32'hFFFF_FFFF || hi_wd !== 32'd77) begin tests_failed++; $display("[TB] FAIL zero_bypass_data: got we=%b lo=%h hi=%0d expected 1 ffffffff 77", lo_we, lo_wd, hi_wd); end
    ex_div_valid = 1'b0;
    @(negedge clock); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_bypass_idle: got %b expected 0", busy); end
`else
    tests_run++; if (div_bus.divide_request_valid !== 1'b1 || div_bus.input2 !== 32'd0) begin tests_failed++; $display("[TB] FAIL zero_issue_req: got req=%b in2=%h expected 1/0", div_bus.divide_request_valid, div_bus.input2); end
    div_bus.divide_result_valid = 1'b1;
    div_bus.divide_result       = 32'hFFFF_FFFF;
    div_bus.divide_remain       = 32'd77;
    @(negedge clock);
    div_bus.divide_result_valid = 1'b0;
    #1;
    tests_run++; if (lo_we !== 1'b1 || lo_wd !== 32'hFFFF_FFFF || hi_wd !== 32'd77) begin tests_failed++; $display("[TB] FAIL zero_issue_data: got we=%b lo=%h hi=%0d expected 1 ffffffff 77", lo_we, lo_wd, hi_wd); end
    ex_div_valid = 1'b0;
    @(negedge clock); #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_issue_idle: got %b expected 0", busy); end
`endif
  endtask

  task automatic test_timeout();
    int req_cycles;
    int err_early;
    req_cycles = 0;
    err_early  = 0;
    drive_op(1'b0, 32'd9, 32'd3);
    for (int i = 1; i <= 34; i++) begin
      @(negedge clock); #1;
      if (div_bus.divide_request_valid === 1'b1) req_cycles++;
      if (timeout_error !== 1'b0) err_early++;
      if (i == 34) ex_div_valid = 1'b0;
    end
    @(negedge clock); #1;
    tests_run++; if (req_cycles !== 34) begin tests_failed++; $display("[TB] FAIL timeout_req_cycles: got %0d expected 34", req_cycles); end
    tests_run++; if (err_early !== 0) begin tests_failed++; $display("[TB] FAIL timeout_early: got %0d early cycles expected 0", err_early); end
    tests_run++; if (timeout_error !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_flag: got %b expected 1", timeout_error); end
    tests_run++; if (div_bus.divide_request_valid !== 1'b0 || busy !== 1'b0 || lo_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_abort: got req=%b busy=%b we=%b expected 0/0/0", div_bus.divide_request_valid, busy, lo_we); end
  endtask

  task automatic test_reset_mid();
    int we_seen;
    int busy_seen;
    we_seen   = 0;
    busy_seen = 0;
    drive_op(1'b0, 32'd20, 32'd4);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    tests_run++; if (div_bus.divide_request_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_state: got req=%b busy=%b expected 0/0", div_bus.divide_request_valid, busy); end
    tests_run++; if (ex_stall !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_stall: got %b expected 0", ex_stall); end
    tests_run++; if (div_bus.input1 !== 32'h0 || div_bus.input2 !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_operands: got %h/%h expected 0/0", div_bus.input1, div_bus.input2); end
    tests_run++; if (timeout_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_timeout: got %b expected 0", timeout_error); end
    @(negedge clock);
    div_bus.divide_result_valid = 1'b1;
    div_bus.divide_result       = 32'd5;
    div_bus.divide_remain       = 32'd0;
    @(negedge clock);
    reset        = 1'b1;
    ex_div_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      if (hi_we || lo_we) we_seen++;
      if (busy) busy_seen++;
      div_bus.divide_result_valid = 1'b0;
    end
    tests_run++; if (we_seen !== 0 || busy_seen !== 0) begin tests_failed++; $display("[TB] FAIL rst_mid_release: got we=%0d busy=%0d cycles expected 0/0", we_seen, busy_seen); end
    tests_run++; if (lo_wd !== 32'h0) begin tests_failed++; $display("[TB] FAIL rst_mid_lo_buf: got %h expected 0", lo_wd); end
  endtask

  initial begin
    $display("[TB] div_sequencer bench start");
    test_reset();
    test_divu();
    test_divs();
    test_flush_idle();
    test_flush();
    test_div_zero();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
